// File: rtl/pio_mem_ultra_mc.sv
// PIO-accessible row table with NUM_CH app read channels sharing one RAM read port with PIO reads.
// Rows span NW PIO words; PIO writes stage the lower lanes and commit the row on the top lane.

`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif
`ifndef PIO_ADDR_MSB
`define PIO_ADDR_MSB 31
`endif

module pio_mem_ultra_mc #(
    parameter int WIDTH       = 64,
    parameter int DEPTH_NBITS = 10,
    parameter int NUM_CH      = 2,
    parameter int LANE_NBITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_div,
    input  logic [`PIO_RANGE]             reg_addr,
    input  logic [`PIO_RANGE]             reg_din,
    input  logic                          reg_rd,
    input  logic                          reg_wr,
    input  logic                          reg_ms,
    input  logic [NUM_CH-1:0]             app_mem_rd,
    input  logic [NUM_CH*DEPTH_NBITS-1:0] app_mem_raddr,
    output logic [NUM_CH-1:0]             app_mem_ack,
    output logic [WIDTH-1:0]              app_mem_rdata,
    output logic [NUM_CH-1:0]             app_mem_err,
    output logic                          mem_ack,
    output logic [`PIO_RANGE]             mem_rdata,
    output logic                          wr_active,
    output logic [DEPTH_NBITS-1:0]        wr_addr,
    output logic [WIDTH-1:0]              wr_data
);

    localparam int PW     = `PIO_NBITS;
    localparam int NW     = 1 << LANE_NBITS;
    localparam int FULLW  = PW * NW;
    localparam int LW     = (LANE_NBITS > 0) ? LANE_NBITS : 1;
    localparam int NREQ   = NUM_CH + 1;
    localparam int IW     = $clog2(NREQ);
    localparam int AW     = `PIO_ADDR_MSB - 1;
    localparam int STW    = (NW > 1) ? (NW - 1) * PW : PW;
    localparam int PIO_ID = NUM_CH;
    localparam int DEPTH  = 1 << DEPTH_NBITS;

    // ------------------------------------------------------------------
    // PIO address decode: dword index = {row, lane}
    // ------------------------------------------------------------------
    logic [AW-1:0]          w_dw_idx;
    logic [DEPTH_NBITS-1:0] w_row;
    logic [LW-1:0]          w_lane;
    logic                   w_unused;
    logic                   w_pio_wr;
    logic                   w_pio_rd;
    logic                   w_commit;

    assign w_dw_idx = reg_addr[`PIO_ADDR_MSB:2];
    assign w_row    = DEPTH_NBITS'(w_dw_idx >> LANE_NBITS);
    assign w_lane   = LW'(w_dw_idx & AW'(NW - 1));
    assign w_unused = &{1'b0, reg_addr[1:0]};

    // A simultaneous read strobe is dropped in favour of the write.
    assign w_pio_wr = reg_ms & reg_wr;
    assign w_pio_rd = reg_ms & reg_rd & ~reg_wr;
    assign w_commit = w_pio_wr && (w_lane == LW'(NW - 1));

    // ------------------------------------------------------------------
    // Write staging and commit
    // ------------------------------------------------------------------
    logic [STW-1:0]   r_stage;
    logic [FULLW-1:0] w_full_row;

    assign w_full_row = (FULLW'(reg_din) << ((NW - 1) * PW))
                      | ((NW > 1) ? FULLW'(r_stage) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage   <= '0;
            wr_active <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_active <= w_commit;
            if (w_commit) begin
                wr_addr <= w_row;
                wr_data <= w_full_row[WIDTH-1:0];
            end
            for (int l = 0; l < NW - 1; l++) begin
                if (w_pio_wr && (w_lane == LW'(l)))
                    r_stage[l*PW +: PW] <= reg_din;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request capture and round-robin arbitration
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]      r_pend;
    logic [DEPTH_NBITS-1:0] r_app_addr [NUM_CH];
    logic                   r_pio_pend;
    logic [DEPTH_NBITS-1:0] r_pio_row;
    logic [LW-1:0]          r_pio_lane;
    logic [IW-1:0]          r_rr_ptr;

    logic [NREQ-1:0]        w_req;
    logic                   w_gnt_vld;
    logic [IW-1:0]          w_gnt_idx;
    logic [NREQ-1:0]        w_gnt_oh;
    logic [DEPTH_NBITS-1:0] w_gnt_addr;

    assign w_req = {r_pio_pend, r_pend};

    // First pass searches from the pointer upward, second pass wraps around.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_vld && w_req[i] && (IW'(i) >= r_rr_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_vld && w_req[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_gnt_oh   = '0;
        w_gnt_addr = r_pio_row;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_vld && (w_gnt_idx == IW'(i)))
                w_gnt_oh[i] = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_idx == IW'(i))
                w_gnt_addr = r_app_addr[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            app_mem_err <= '0;
            r_pio_pend  <= 1'b0;
            r_pio_row   <= '0;
            r_pio_lane  <= '0;
            r_rr_ptr    <= '0;
            for (int i = 0; i < NUM_CH; i++)
                r_app_addr[i] <= '0;
        end else begin
            r_pend      <= (r_pend & ~w_gnt_oh[NUM_CH-1:0]) | (app_mem_rd & ~r_pend);
            app_mem_err <= app_mem_err | (app_mem_rd & r_pend);
            for (int i = 0; i < NUM_CH; i++) begin
                if (app_mem_rd[i] && !r_pend[i])
                    r_app_addr[i] <= app_mem_raddr[i*DEPTH_NBITS +: DEPTH_NBITS];
            end
            r_pio_pend <= (r_pio_pend & ~w_gnt_oh[PIO_ID]) | (w_pio_rd & ~r_pio_pend);
            if (w_pio_rd && !r_pio_pend) begin
                r_pio_row  <= w_row;
                r_pio_lane <= w_lane;
            end
            if (w_gnt_vld)
                r_rr_ptr <= (w_gnt_idx == IW'(PIO_ID)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Row RAM: writes land one cycle after commit, reads are read-first
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_ram_q;

    // NOTE: the array has no reset branch so it maps onto block RAM; a same-row
    // write in this cycle is not seen by the read because both use <=.
    always_ff @(posedge clk) begin
        if (wr_active)
            r_mem[wr_addr] <= wr_data;
        r_ram_q <= r_mem[w_gnt_addr];
    end

    // ------------------------------------------------------------------
    // Read pipeline: grant -> array read -> output register -> return
    // ------------------------------------------------------------------
    logic             r_s1_vld;
    logic [IW-1:0]    r_s1_who;
    logic [LW-1:0]    r_s1_lane;
    logic             r_s2_vld;
    logic [IW-1:0]    r_s2_who;
    logic [LW-1:0]    r_s2_lane;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_n_ack;
    logic             w_pio_rdy;
    logic [FULLW-1:0] w_row_pad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_who  <= '0;
            r_s1_lane <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_who  <= '0;
            r_s2_lane <= '0;
        end else begin
            r_s1_vld  <= w_gnt_vld;
            r_s1_who  <= w_gnt_idx;
            r_s1_lane <= r_pio_lane;
            r_s2_vld  <= r_s1_vld;
            r_s2_who  <= r_s1_who;
            r_s2_lane <= r_s1_lane;
        end
    end

    always_ff @(posedge clk) begin
        r_s2_data <= r_ram_q;
    end

    assign w_pio_rdy = r_s2_vld && (r_s2_who == IW'(PIO_ID));
    assign w_row_pad = FULLW'(r_s2_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_mem_ack   <= '0;
            app_mem_rdata <= '0;
            mem_rdata     <= '0;
            r_n_ack       <= 1'b0;
            mem_ack       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                app_mem_ack[i] <= r_s2_vld && (r_s2_who == IW'(i));
            if (r_s2_vld && (r_s2_who != IW'(PIO_ID)))
                app_mem_rdata <= r_s2_data;
            if (w_pio_rdy) begin
                for (int l = 0; l < NW; l++) begin
                    if (r_s2_lane == LW'(l))
                        mem_rdata <= w_row_pad[l*PW +: PW];
                end
            end
            // Ack is held pending until the next PIO-domain strobe picks it up.
            if (w_pio_wr || w_pio_rdy)
                r_n_ack <= 1'b1;
            else if (clk_div)
                r_n_ack <= 1'b0;
            if (clk_div)
                mem_ack <= r_n_ack;
        end
    end

endmodule
